instruction_controller: RTL

INSTRUCTION_CONTROLLER -- requirements
Module: instruction_controller

---
 rtl/instruction_controller.sv | 206 ++++++++++++++++++++
 1 files changed

// File: rtl/instruction_controller.sv
// rtl/instruction_controller.sv - fetch/decode/execute/increment control unit for a 4-bit-address CPU.
// Optional phase-order checker enabled by defining PHASE_CHECK_EN.
module instruction_controller (
  input  logic       clock,
  input  logic       input_clear,
  input  logic       input_fetch,
  input  logic       input_decode,
  input  logic       input_execute,
  input  logic       input_increment,
  input  logic [7:0] input_data,
  input  logic       input_zero_flag,
  input  logic       input_carry_flag,
  output logic [3:0] output_address,
  output logic [3:0] output_opcode,
  output logic       output_load_a,
  output logic       output_load_b,
  output logic       output_alu_sub,
  output logic       output_mem_write,
  output logic       output_out_load,
  output logic       output_clock_enable,
  output logic       output_phase_error
);

  localparam logic [3:0] OP_LDA = 4'h1;
  localparam logic [3:0] OP_ADD = 4'h2;
  localparam logic [3:0] OP_SUB = 4'h3;
  localparam logic [3:0] OP_STA = 4'h4;
  localparam logic [3:0] OP_LDI = 4'h5;
  localparam logic [3:0] OP_JMP = 4'h6;
  localparam logic [3:0] OP_JC  = 4'h7;
  localparam logic [3:0] OP_JZ  = 4'h8;
  localparam logic [3:0] OP_OUT = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

  typedef struct packed {
    logic load_a;
    logic add;
    logic sub;
    logic sta;
    logic out;
    logic jump;
    logic halt;
  } ctrl_t;

  logic [3:0] pc_q, pc_d;
  logic [7:0] ir_q, ir_d;
  ctrl_t      cw_q, cw_d, cw_dec;
  logic       load_a_q, load_a_d;
  logic       load_b_q, load_b_d;
  logic       alu_sub_q, alu_sub_d;
  logic       mem_write_q, mem_write_d;
  logic       out_load_q, out_load_d;
  logic       pend_q, pend_d;
  logic       pend_sub_q, pend_sub_d;
  logic       halt_q, halt_d;
  logic       do_fetch, do_decode, do_execute, do_increment;

`ifdef PHASE_CHECK_EN
  typedef enum logic [1:0] {
    WAIT_FETCH,
    WAIT_DECODE,
    WAIT_EXECUTE,
    WAIT_INCREMENT
  } phase_e;

  phase_e     phase_q, phase_d;
  logic       phase_err;
  logic       perr_q;
  logic [2:0] strobe_cnt;

  always_ff @(posedge clock or posedge input_clear) begin
    if (input_clear) begin
      phase_q <= WAIT_FETCH;
      perr_q  <= 1'b0;
    end else begin
      phase_q <= phase_d;
      perr_q  <= perr_q | phase_err;
    end
  end

  // Exactly one strobe, and only the one the FSM waits for, is allowed to act.
  always_comb begin
    phase_d      = phase_q;
    phase_err    = 1'b0;
    do_fetch     = 1'b0;
    do_decode    = 1'b0;
    do_execute   = 1'b0;
    do_increment = 1'b0;
    strobe_cnt   = {2'b00, input_fetch} + {2'b00, input_decode}
                 + {2'b00, input_execute} + {2'b00, input_increment};
    if (strobe_cnt == 3'd1) begin
      case (phase_q)
        WAIT_FETCH:
          if (input_fetch) begin do_fetch = 1'b1; phase_d = WAIT_DECODE; end
          else phase_err = 1'b1;
        WAIT_DECODE:
          if (input_decode) begin do_decode = 1'b1; phase_d = WAIT_EXECUTE; end
          else phase_err = 1'b1;
        WAIT_EXECUTE:
          if (input_execute) begin do_execute = 1'b1; phase_d = WAIT_INCREMENT; end
          else phase_err = 1'b1;
        WAIT_INCREMENT:
          if (input_increment) begin do_increment = 1'b1; phase_d = WAIT_FETCH; end
          else phase_err = 1'b1;
        default: phase_d = WAIT_FETCH;
      endcase
    end else if (strobe_cnt != 3'd0) begin
      phase_err = 1'b1;
    end
  end

  assign output_phase_error = perr_q;
`else
  always_comb begin
    do_fetch     = input_fetch;
    do_decode    = input_decode & ~input_fetch;
    do_execute   = input_execute & ~input_decode & ~input_fetch;
    do_increment = input_increment & ~input_execute & ~input_decode & ~input_fetch;
  end

  assign output_phase_error = 1'b0;
`endif

  // Jump decisions are frozen at decode using the flags present then.
  always_comb begin
    cw_dec = '0;
    case (ir_q[7:4])
      OP_LDA, OP_LDI: cw_dec.load_a = 1'b1;
      OP_ADD:         cw_dec.add    = 1'b1;
      OP_SUB:         cw_dec.sub    = 1'b1;
      OP_STA:         cw_dec.sta    = 1'b1;
      OP_OUT:         cw_dec.out    = 1'b1;
      OP_JMP:         cw_dec.jump   = 1'b1;
      OP_JC:          cw_dec.jump   = input_carry_flag;
      OP_JZ:          cw_dec.jump   = input_zero_flag;
      OP_HLT:         cw_dec.halt   = 1'b1;
      default:        cw_dec        = '0;
    endcase
  end

  always_comb begin
    pc_d        = pc_q;
    ir_d        = ir_q;
    cw_d        = cw_q;
    halt_d      = halt_q;
    load_a_d    = pend_q;
    load_b_d    = 1'b0;
    alu_sub_d   = pend_sub_q;
    mem_write_d = 1'b0;
    out_load_d  = 1'b0;
    pend_d      = 1'b0;
    pend_sub_d  = 1'b0;
    if (do_fetch) ir_d = input_data;
    if (do_decode) cw_d = cw_dec;
    if (do_execute) begin
      load_a_d    = load_a_d | cw_q.load_a;
      load_b_d    = cw_q.add | cw_q.sub;
      alu_sub_d   = alu_sub_d | cw_q.sub;
      mem_write_d = cw_q.sta;
      out_load_d  = cw_q.out;
      pend_d      = cw_q.add | cw_q.sub;
      pend_sub_d  = cw_q.sub;
      if (cw_q.jump) pc_d = ir_q[3:0];
      if (cw_q.halt) halt_d = 1'b1;
    end
    if (do_increment && !cw_q.jump) pc_d = pc_q + 4'd1;
  end

  always_ff @(posedge clock or posedge input_clear) begin
    if (input_clear) begin
      pc_q        <= '0;
      ir_q        <= '0;
      cw_q        <= '0;
      load_a_q    <= 1'b0;
      load_b_q    <= 1'b0;
      alu_sub_q   <= 1'b0;
      mem_write_q <= 1'b0;
      out_load_q  <= 1'b0;
      pend_q      <= 1'b0;
      pend_sub_q  <= 1'b0;
      halt_q      <= 1'b0;
    end else begin
      pc_q        <= pc_d;
      ir_q        <= ir_d;
      cw_q        <= cw_d;
      load_a_q    <= load_a_d;
      load_b_q    <= load_b_d;
      alu_sub_q   <= alu_sub_d;
      mem_write_q <= mem_write_d;
      out_load_q  <= out_load_d;
      pend_q      <= pend_d;
      pend_sub_q  <= pend_sub_d;
      halt_q      <= halt_d;
    end
  end

  assign output_address      = input_fetch ? pc_q : ir_q[3:0];
  assign output_opcode       = ir_q[7:4];
  assign output_load_a       = load_a_q;
  assign output_load_b       = load_b_q;
  assign output_alu_sub      = alu_sub_q;
  assign output_mem_write    = mem_write_q;
  assign output_out_load     = out_load_q;
  assign output_clock_enable = ~halt_q;

endmodule
